// File: rtl/sfp_pkg.sv
// Shared definitions for the special-function processor array:
// activation encodings and the per-beat mode bundle that travels with data.
package sfp_pkg;

   localparam logic [1:0] ACT_NONE  = 2'b00;
   localparam logic [1:0] ACT_RELU  = 2'b01;
   localparam logic [1:0] ACT_LEAKY = 2'b10;

   typedef struct packed {
      logic       passthrough;
      logic       accum;
      logic [1:0] act;
   } mode_t;

endpackage

// File: rtl/sfp_lane.sv
// One channel of the SFP array: pre-activation select/add and the activation stage.
// Optional macro SFP_SAT_EN makes the accumulate add saturate instead of wrap.
module sfp_lane
   import sfp_pkg::*;
#(
   parameter int psum_bw    = 16,
   parameter int leak_shift = 3
) (
   input  logic [psum_bw-1:0] psum,
   input  logic [psum_bw-1:0] ofifo,
   input  logic               passthrough,
   input  logic               accum,
   output logic [psum_bw-1:0] pre,
   input  logic [psum_bw-1:0] pre_q,
   input  logic               bypass_q,
   input  logic [1:0]         act_q,
   output logic [psum_bw-1:0] result
);

   logic [psum_bw-1:0] sum_sel;
   logic [psum_bw-1:0] leaky_v;

`ifdef SFP_SAT_EN
   logic [psum_bw:0] sum_ext;

   // Overflow shows as the two top bits of the sign-extended sum disagreeing.
   always_comb begin
      sum_ext = {psum[psum_bw-1], psum} + {ofifo[psum_bw-1], ofifo};
      if (sum_ext[psum_bw] != sum_ext[psum_bw-1])
         sum_sel = sum_ext[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                    : {1'b0, {(psum_bw-1){1'b1}}};
      else
         sum_sel = sum_ext[psum_bw-1:0];
   end
`else
   assign sum_sel = psum + ofifo;
`endif

   always_comb begin
      if (passthrough)
         pre = ofifo;
      else if (accum)
         pre = sum_sel;
      else
         pre = psum;
   end

   assign leaky_v = $signed(pre_q) >>> leak_shift;

   always_comb begin
      result = pre_q;
      if (!bypass_q) begin
         case (act_q)
            ACT_RELU:  result = pre_q[psum_bw-1] ? '0 : pre_q;
            ACT_LEAKY: result = pre_q[psum_bw-1] ? leaky_v : pre_q;
            default:   result = pre_q;
         endcase
      end
   end

endmodule

// File: rtl/sfp_array.sv
// Multi-channel pipelined special-function processor: two register stages with
// valid/ready backpressure and a hand-off beat counter. SFP_SAT_EN selects saturating add.
module sfp_array
   import sfp_pkg::*;
#(
   parameter int col        = 8,
   parameter int psum_bw    = 16,
   parameter int leak_shift = 3,
   parameter int cnt_bw     = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [col*psum_bw-1:0] psum_in,
   input  logic [col*psum_bw-1:0] ofifo_in,
   input  logic                   passthrough,
   input  logic                   accum,
   input  logic [1:0]             act,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [col*psum_bw-1:0] sfp_out,
   output logic [cnt_bw-1:0]      beat_cnt,
   input  logic                   cnt_clr
);

   mode_t                  in_mode;
   logic                   en;
   logic [col*psum_bw-1:0] pre_flat;
   logic [col*psum_bw-1:0] res_flat;

   logic                   s1_valid;
   logic                   s1_pt;
   logic [1:0]             s1_act;
   logic [col*psum_bw-1:0] s1_data;

   assign in_mode = '{passthrough: passthrough, accum: accum, act: act};

   // NOTE: in_ready is combinational from out_ready so a full pipe can accept
   // and hand off in the same cycle; the upstream must not loop in_ready into out_ready.
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   for (genvar k = 0; k < col; k++) begin : g_lane
      sfp_lane #(
         .psum_bw    (psum_bw),
         .leak_shift (leak_shift)
      ) u_lane (
         .psum        (psum_in[k*psum_bw +: psum_bw]),
         .ofifo       (ofifo_in[k*psum_bw +: psum_bw]),
         .passthrough (in_mode.passthrough),
         .accum       (in_mode.accum),
         .pre         (pre_flat[k*psum_bw +: psum_bw]),
         .pre_q       (s1_data[k*psum_bw +: psum_bw]),
         .bypass_q    (s1_pt),
         .act_q       (s1_act),
         .result      (res_flat[k*psum_bw +: psum_bw])
      );
   end

   // NOTE: all state uses non-blocking assignments so every stage samples the
   // previous-cycle value of the stage ahead of it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_pt    <= 1'b0;
         s1_act   <= ACT_NONE;
         s1_data  <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_pt   <= in_mode.passthrough;
            s1_act  <= in_mode.act;
            s1_data <= pre_flat;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         sfp_out   <= '0;
      end else if (en) begin
         out_valid <= s1_valid;
         if (s1_valid)
            sfp_out <= res_flat;
      end
   end

   // Clear wins over a simultaneous hand-off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         beat_cnt <= '0;
      else if (cnt_clr)
         beat_cnt <= '0;
      else if (out_valid && out_ready)
         beat_cnt <= beat_cnt + cnt_bw'(1);
   end

endmodule
